// File: rtl/bg_objects_ctrl.sv
// bg_objects_ctrl: background cloud scheduler.
// Each frame tick the controller scrolls the active clouds left, retires any
// that reach the left edge, and spawns a new one when the spawn counter
// expires. On every pixel it picks the lowest-index cloud covering that pixel
// and drives the shared 8x8 sprite ROM address (sprite scaled x4 to 32x32).
//
// Optional build macro: BG_RANDOM_SPAWN_EN
//   When defined, the LFSR randomises the spawn interval and the spawn y.
//   When undefined, clouds spawn every SPAWN_PERIOD frames at y = Y_TOP.
//
// state | meaning
// IDLE  | wait for an unhalted frame tick
// MOVE  | scroll/retire active slots, step the LFSR
// SPAWN | count down, or load the lowest free slot when the count is zero
module bg_objects_ctrl #(
  parameter int NUM_CLOUDS   = 2,
  parameter int SCREEN_W     = 640,
  parameter int Y_TOP        = 40,
  parameter int SCROLL_SPEED = 2,
  parameter int SPAWN_PERIOD = 64,
  parameter int SPAWN_MIN    = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            i_hpos,
  input  logic [9:0]            i_vpos,
  input  logic                  i_frame_tick,
  input  logic                  i_halt,
  input  logic                  i_restart,
  output logic [5:0]            o_rom_counter,
  output logic                  o_bg_hit,
  output logic [NUM_CLOUDS-1:0] o_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    SPAWN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [9:0]            slot_x [NUM_CLOUDS];
  logic [9:0]            slot_y [NUM_CLOUDS];
  logic [NUM_CLOUDS-1:0] slot_act;
  logic [NUM_CLOUDS-1:0] spawn_sel;
  logic                  slot_free;

  logic [7:0] spawn_cnt;
  logic [7:0] lfsr;
  logic [7:0] lfsr_nxt;
  logic [7:0] reload_val;
  logic [9:0] spawn_y;

  logic [9:0]            dx [NUM_CLOUDS];
  logic [9:0]            dy [NUM_CLOUDS];
  logic [NUM_CLOUDS-1:0] slot_hit;
  logic                  pix_hit;
  logic [5:0]            pix_addr;

  // Catch parameter sets the fixed-width counters and address cannot hold.
  if (NUM_CLOUDS < 1 || NUM_CLOUDS > 4 || SPAWN_MIN > 224 || SPAWN_PERIOD > 255) begin : g_bad_param
    $error("bg_objects_ctrl: parameter out of range");
  end

  // Fibonacci LFSR, taps 8,6,5,4, shifting left.
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

`ifdef BG_RANDOM_SPAWN_EN
  assign reload_val = 8'(SPAWN_MIN) + {3'b000, lfsr[4:0]};
  assign spawn_y    = 10'(Y_TOP) + {4'b0000, lfsr[7:5], 3'b000};
`else
  assign reload_val = 8'(SPAWN_PERIOD);
  assign spawn_y    = 10'(Y_TOP);
`endif

  assign o_active = slot_act;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; restart always forces IDLE so a coincident tick is lost.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_frame_tick && !i_halt) state_nxt = MOVE;
      MOVE:    state_nxt = SPAWN;
      SPAWN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_restart) state_nxt = IDLE;
  end

  // Lowest-index free slot, one-hot.
  always_comb begin
    spawn_sel = '0;
    slot_free = 1'b0;
    for (int i = 0; i < NUM_CLOUDS; i++) begin
      if (!slot_act[i] && !slot_free) begin
        spawn_sel[i] = 1'b1;
        slot_free    = 1'b1;
      end
    end
  end

  // Slot state: scroll/retire in MOVE, load a new cloud in SPAWN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_act <= '0;
      for (int i = 0; i < NUM_CLOUDS; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
    end else if (i_restart) begin
      slot_act <= '0;
    end else if (state == MOVE) begin
      for (int i = 0; i < NUM_CLOUDS; i++) begin
        if (slot_act[i]) begin
          if (slot_x[i] > 10'(SCROLL_SPEED)) slot_x[i] <= slot_x[i] - 10'(SCROLL_SPEED);
          else                               slot_act[i] <= 1'b0;
        end
      end
    end else if (state == SPAWN && spawn_cnt == 8'd0) begin
      for (int i = 0; i < NUM_CLOUDS; i++) begin
        if (spawn_sel[i]) begin
          slot_x[i]   <= 10'(SCREEN_W);
          slot_y[i]   <= spawn_y;
          slot_act[i] <= 1'b1;
        end
      end
    end
  end

  // Spawn counter and LFSR; a full pool leaves the counter parked at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spawn_cnt <= 8'(SPAWN_PERIOD);
      lfsr      <= 8'hA5;
    end else if (i_restart) begin
      spawn_cnt <= 8'(SPAWN_PERIOD);
    end else begin
      if (state == MOVE) lfsr <= lfsr_nxt;
      if (state == SPAWN) begin
        if (spawn_cnt != 8'd0) spawn_cnt <= spawn_cnt - 8'd1;
        else if (slot_free)    spawn_cnt <= reload_val;
      end
    end
  end

  // Per-slot hit test and fixed-priority pick (lowest index evaluated last wins).
  always_comb begin
    pix_hit  = 1'b0;
    pix_addr = o_rom_counter;
    for (int i = 0; i < NUM_CLOUDS; i++) begin
      dx[i]       = i_hpos - slot_x[i];
      dy[i]       = i_vpos - slot_y[i];
      slot_hit[i] = slot_act[i] && (i_hpos >= slot_x[i]) && (dx[i] < 10'd32)
                    && (i_vpos >= slot_y[i]) && (dy[i] < 10'd32);
    end
    for (int i = NUM_CLOUDS - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        pix_hit  = 1'b1;
        pix_addr = {dy[i][4:2], dx[i][4:2]};
      end
    end
  end

  // Registered pixel outputs; the address holds when no cloud is hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_bg_hit      <= 1'b0;
      o_rom_counter <= 6'd0;
    end else begin
      o_bg_hit      <= pix_hit;
      o_rom_counter <= pix_addr;
    end
  end

endmodule

// File: tb/tb_bg_objects_ctrl.sv
// Directed bench for bg_objects_ctrl: default instance plus a short-period
// instance sharing the same stimulus so two overlapping clouds can be built.
module tb_bg_objects_ctrl;

  logic       clk;
  logic       rst_n;
  logic [9:0] i_hpos;
  logic [9:0] i_vpos;
  logic       i_frame_tick;
  logic       i_halt;
  logic       i_restart;
  logic [5:0] o_rom_counter;
  logic       o_bg_hit;
  logic [1:0] o_active;
  logic [5:0] o_rom_counter2;
  logic       o_bg_hit2;
  logic [1:0] o_active2;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_lfsr;

  bg_objects_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_hpos(i_hpos), .i_vpos(i_vpos),
    .i_frame_tick(i_frame_tick), .i_halt(i_halt), .i_restart(i_restart),
    .o_rom_counter(o_rom_counter), .o_bg_hit(o_bg_hit), .o_active(o_active)
  );

  bg_objects_ctrl #(.SPAWN_PERIOD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_hpos(i_hpos), .i_vpos(i_vpos),
    .i_frame_tick(i_frame_tick), .i_halt(i_halt), .i_restart(i_restart),
    .o_rom_counter(o_rom_counter2), .o_bg_hit(o_bg_hit2), .o_active(o_active2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Pulse the tick; returns 1ns into the MOVE cycle.
  task automatic tick_start();
    @(posedge clk); #1 i_frame_tick = 1'b1;
    @(posedge clk); #1 i_frame_tick = 1'b0;
  endtask

  task automatic tick_finish();
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic tick();
    tick_start();
    tick_finish();
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v);
    i_hpos = h;
    i_vpos = v;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    i_hpos       = '0;
    i_vpos       = '0;
    i_frame_tick = 1'b0;
    i_halt       = 1'b0;
    i_restart    = 1'b0;
    exp_lfsr     = 8'hA5;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_active",  32'(o_active), 32'h0);
    check("rst_hit",     32'(o_bg_hit), 32'h0);
    check("rst_rom",     32'(o_rom_counter), 32'h0);
    check("rst_cnt",     32'(dut.spawn_cnt), 32'd64);
    check("rst_lfsr",    32'(dut.lfsr), 32'hA5);

    for (int n = 1; n <= 65; n++) begin
      tick();
      exp_lfsr = lfsr_step(exp_lfsr);
      if (n == 9) begin
        // dut2 (period 2): slots at 628/634, pool full, counter parked at 0
        check("ov_active",  32'(o_active2), 32'h3);
        check("ov_x0",      32'(dut2.slot_x[0]), 32'd628);
        check("ov_x1",      32'(dut2.slot_x[1]), 32'd634);
        check("ov_cnt",     32'(dut2.spawn_cnt), 32'd0);
        pix(10'd645, 10'd45);
        check("ov_hit",     32'(o_bg_hit2), 32'h1);
        check("ov_rom_pri", 32'(o_rom_counter2), 32'o14);
        pix(10'd665, 10'd45);
        check("ov_rom_s1",  32'(o_rom_counter2), 32'o17);
        tick();
        check("ov_cnt_hold", 32'(dut2.spawn_cnt), 32'd0);
        check("ov_full",    32'(o_active2), 32'h3);
        exp_lfsr = lfsr_step(exp_lfsr);
        n++;
      end
      if (n == 64) begin
        check("t64_active", 32'(o_active), 32'h0);
        check("t64_cnt",    32'(dut.spawn_cnt), 32'd0);
      end
    end
    check("t65_active", 32'(o_active), 32'h1);
    check("t65_x0",     32'(dut.slot_x[0]), 32'd640);
`ifdef BG_RANDOM_SPAWN_EN
    check("t65_y0_mul8", 32'(dut.slot_y[0] % 8), 32'd0);
    check("t65_y0_rng", 32'((dut.slot_y[0] >= 40) && (dut.slot_y[0] <= 96)), 32'd1);
`else
    check("t65_y0",     32'(dut.slot_y[0]), 32'd40);
    check("t65_cnt",    32'(dut.spawn_cnt), 32'd64);
`endif
    check("t65_lfsr",   32'(dut.lfsr), 32'(exp_lfsr));

    tick();
    exp_lfsr = lfsr_step(exp_lfsr);
    check("t66_x0", 32'(dut.slot_x[0]), 32'd638);
    pix(10'd645, 10'd50);
    check("pix_hit", 32'(o_bg_hit), 32'h1);
    check("pix_rom", 32'(o_rom_counter), 32'o21);
    pix(10'd637, 10'd50);
    check("pix_left_miss", 32'(o_bg_hit), 32'h0);
    check("pix_rom_hold",  32'(o_rom_counter), 32'o21);
    pix(10'd669, 10'd71);
    check("pix_corner_hit", 32'(o_bg_hit), 32'h1);
    check("pix_corner_rom", 32'(o_rom_counter), 32'o77);
    pix(10'd670, 10'd71);
    check("pix_right_miss", 32'(o_bg_hit), 32'h0);
    pix(10'd645, 10'd72);
    check("pix_bottom_miss", 32'(o_bg_hit), 32'h0);
    check("pix_rom_hold2",   32'(o_rom_counter), 32'o77);
    pix(10'd0, 10'd0);

    for (int n = 67; n <= 384; n++) begin
      tick();
      exp_lfsr = lfsr_step(exp_lfsr);
    end
    check("t384_x0",     32'(dut.slot_x[0]), 32'd2);
    check("t384_x1",     32'(dut.slot_x[1]), 32'd132);
    check("t384_active", 32'(o_active), 32'h3);
    check("t384_cnt",    32'(dut.spawn_cnt), 32'd0);

    // x0 == SCROLL_SPEED retires in MOVE; the freed slot respawns in SPAWN
    tick_start();
    @(posedge clk); #1;
    exp_lfsr = lfsr_step(exp_lfsr);
    check("retire_active", 32'(o_active), 32'h2);
    @(posedge clk); #1;
    check("respawn_active", 32'(o_active), 32'h3);
    check("respawn_x0",     32'(dut.slot_x[0]), 32'd640);
    check("respawn_x1",     32'(dut.slot_x[1]), 32'd130);
    check("respawn_cnt",    32'(dut.spawn_cnt), 32'd64);

    i_halt = 1'b1;
    for (int n = 0; n < 10; n++) tick();
    i_halt = 1'b0;
    check("halt_x0",   32'(dut.slot_x[0]), 32'd640);
    check("halt_x1",   32'(dut.slot_x[1]), 32'd130);
    check("halt_cnt",  32'(dut.spawn_cnt), 32'd64);
    check("halt_lfsr", 32'(dut.lfsr), 32'(exp_lfsr));

    pix(10'd650, 10'd60);
    check("pre_rst_rom", 32'(o_rom_counter), 32'o52);

    @(posedge clk); #1 i_frame_tick = 1'b1; i_restart = 1'b1;
    @(posedge clk); #1 i_frame_tick = 1'b0; i_restart = 1'b0;
    tick_finish();
    check("restart_active", 32'(o_active), 32'h0);
    check("restart_cnt",    32'(dut.spawn_cnt), 32'd64);
    check("restart_state",  32'(dut.state), 32'd0);
    check("restart_lfsr",   32'(dut.lfsr), 32'(exp_lfsr));
    check("restart_nohit",  32'(o_bg_hit), 32'h0);
    check("restart_rom",    32'(o_rom_counter), 32'o52);

    tick_start();
    check("mid_move_state", 32'(dut.state), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rom",    32'(o_rom_counter), 32'h0);
    check("arst_hit",    32'(o_bg_hit), 32'h0);
    check("arst_active", 32'(o_active), 32'h0);
    check("arst_lfsr",   32'(dut.lfsr), 32'hA5);
    check("arst_state",  32'(dut.state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
